// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t       : execute-stage forwarding mux select
//   mem_state_t     : data-memory miss sequencer state
//   RESULT_SRC_LOAD : ResultSrcE encoding of a load
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // operand from register file
    FWD_W  = 2'b01,  // operand from writeback result
    FWD_M  = 2'b10   // operand from memory-stage ALU result
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Execute-stage forwarding compare (pure combinational).
// Ports:
//   Rs1E, Rs2E            : source registers in execute
//   RdM, RdW              : destination registers in memory / writeback
//   RegWriteM, RegWriteW  : register write enables in memory / writeback
//   ForwardAE, ForwardBE  : operand A / B mux selects (00 RF, 10 M, 01 W)
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] Rs1E,
  input  logic [ADDR_WIDTH-1:0] Rs2E,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
);

  // Memory stage holds the younger result, so it wins over writeback.
  // x0 is hard-wired zero and is never forwarded.
  function automatic fwd_sel_t fwd_pick(input logic [ADDR_WIDTH-1:0] rs);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (RegWriteM && (RdM == rs)) begin
        sel = FWD_M;
      end else if (RegWriteW && (RdW == rs)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_pick(Rs1E);
    ForwardBE = fwd_pick(Rs2E);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard and stall scheduler for the 5-stage core.
// Drives stage-register stall/flush controls and the execute forwarding muxes,
// and sequences data-memory miss stalls with a timeout watchdog.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   Rs1D, Rs2D                    : decode source registers
//   Rs1E, Rs2E, RdE               : execute source / destination registers
//   RdM, RdW                      : memory / writeback destination registers
//   ResultSrcE                    : execute result select (01 = load)
//   RegWriteM, RegWriteW          : register write enables in M / W
//   PCSrcE                        : taken branch/jump resolved in execute
//   MemReqM, MemAckM              : memory-stage access request / completion
//   ForwardAE, ForwardBE          : forwarding selects
//   StallF/D/E/M                  : hold the stage register
//   FlushD/E/W                    : synchronous clear of the stage register
//   MemTimeoutErr                 : sticky miss-timeout flag
// Optional build macro HAZARD_PERF_CNT_EN adds saturating performance counters:
//   StallCycles, LoadUseCount, FlushCount (CNT_WIDTH bits each).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  input  logic [ADDR_WIDTH-1:0] Rs1E,
  input  logic [ADDR_WIDTH-1:0] Rs2E,
  input  logic [ADDR_WIDTH-1:0] RdE,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemAckM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]  StallCycles,
  output logic [CNT_WIDTH-1:0]  LoadUseCount,
  output logic [CNT_WIDTH-1:0]  FlushCount,
`endif
  output logic                  MemTimeoutErr
);

  localparam int unsigned WaitCntWidth = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitCntWidth-1:0] WaitCntMax = WaitCntWidth'(MEM_TIMEOUT);

  // Elaboration-time parameter sanity checks.
  if (MEM_TIMEOUT < 2) begin : g_bad_timeout
    $error("hazard_ctrl: MEM_TIMEOUT must be >= 2");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("hazard_ctrl: CNT_WIDTH must be >= 1");
  end

  mem_state_t               state_q;
  logic [WaitCntWidth-1:0]  wait_cnt_q;
  logic                     err_q;

  logic       lw_stall;
  logic       mem_stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  hazard_fwd_unit #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (fwd_a),
    .ForwardBE (fwd_b)
  );

  always_comb begin
    lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
    // Mealy: the miss stall asserts in the same cycle the request misses and
    // drops in the same cycle the ack arrives.
    mem_stall = ((state_q == RUN) && MemReqM && !MemAckM) ||
                ((state_q == MEM_WAIT) && !MemAckM);
  end

  // While in reset the pipeline is held cleared, regardless of inputs.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (rst_n) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (mem_stall) begin
        // Whole pipe freezes; a pending redirect is re-evaluated after release.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushE = lw_stall | PCSrcE;
        FlushD = PCSrcE;
        FlushW = 1'b0;
      end
    end
  end

  assign MemTimeoutErr = err_q;

  // Miss sequencer with saturating wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if ((state_q == MEM_WAIT) && (wait_cnt_q == WaitCntMax)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        RUN: begin
          if (MemReqM && !MemAckM) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WaitCntWidth'(1);
          end
        end
        MEM_WAIT: begin
          if (MemAckM) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q != WaitCntMax) begin
            wait_cnt_q <= wait_cnt_q + WaitCntWidth'(1);
          end
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cycles_q;
  logic [CNT_WIDTH-1:0] load_use_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      load_use_q     <= '0;
      flush_cnt_q    <= '0;
    end else begin
      if (mem_stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CNT_WIDTH'(1);
      end
      if (lw_stall && !mem_stall && (load_use_q != '1)) begin
        load_use_q <= load_use_q + CNT_WIDTH'(1);
      end
      if (PCSrcE && !mem_stall && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign StallCycles  = stall_cycles_q;
  assign LoadUseCount = load_use_q;
  assign FlushCount   = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven single-cycle vectors plus
// hand-written miss, timeout and reset-mid-miss sequences. Expected outputs are
// queued when stimulus is driven and compared mid-cycle.
module tb_hazard_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned TO = 4;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]    rsrc;
    logic          rwm, rww, pcs, req, ack;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       sf, sd, se, sm, fd, fe, fw, err;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t ex;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeoutErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] StallCycles, LoadUseCount, FlushCount;
`endif

  hazard_ctrl #(
    .ADDR_WIDTH  (AW),
    .MEM_TIMEOUT (TO),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Rs1D          (Rs1D),
    .Rs2D          (Rs2D),
    .Rs1E          (Rs1E),
    .Rs2E          (Rs2E),
    .RdE           (RdE),
    .RdM           (RdM),
    .RdW           (RdW),
    .ResultSrcE    (ResultSrcE),
    .RegWriteM     (RegWriteM),
    .RegWriteW     (RegWriteW),
    .PCSrcE        (PCSrcE),
    .MemReqM       (MemReqM),
    .MemAckM       (MemAckM),
    .ForwardAE     (ForwardAE),
    .ForwardBE     (ForwardBE),
    .StallF        (StallF),
    .StallD        (StallD),
    .StallE        (StallE),
    .StallM        (StallM),
    .FlushD        (FlushD),
    .FlushE        (FlushE),
    .FlushW        (FlushW),
`ifdef HAZARD_PERF_CNT_EN
    .StallCycles   (StallCycles),
    .LoadUseCount  (LoadUseCount),
    .FlushCount    (FlushCount),
`endif
    .MemTimeoutErr (MemTimeoutErr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  exp_t  exp_q[$];
  string name_q[$];

  function automatic in_t mk(input logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                             input logic [1:0] rsrc, input logic rwm, rww, pcs, req, ack);
    in_t i;
    i.rs1d = rs1d; i.rs2d = rs2d; i.rs1e = rs1e; i.rs2e = rs2e;
    i.rde  = rde;  i.rdm  = rdm;  i.rdw  = rdw;  i.rsrc = rsrc;
    i.rwm  = rwm;  i.rww  = rww;  i.pcs  = pcs;  i.req  = req; i.ack = ack;
    return i;
  endfunction

  // Normal (no miss) expectation: StallD tracks StallF, E/M never stall, no W flush.
  function automatic exp_t ex_run(input logic [1:0] fa, fb, input logic stl, fd, fe, err);
    exp_t e;
    e.fa = fa; e.fb = fb; e.sf = stl; e.sd = stl; e.se = 1'b0; e.sm = 1'b0;
    e.fd = fd; e.fe = fe; e.fw = 1'b0; e.err = err;
    return e;
  endfunction

  function automatic exp_t ex_mem(input logic err);
    exp_t e;
    e.fa = 2'b00; e.fb = 2'b00; e.sf = 1'b1; e.sd = 1'b1; e.se = 1'b1; e.sm = 1'b1;
    e.fd = 1'b0; e.fe = 1'b0; e.fw = 1'b1; e.err = err;
    return e;
  endfunction

  function automatic exp_t ex_rst();
    exp_t e;
    e.fa = 2'b00; e.fb = 2'b00; e.sf = 1'b0; e.sd = 1'b0; e.se = 1'b0; e.sm = 1'b0;
    e.fd = 1'b1; e.fe = 1'b1; e.fw = 1'b1; e.err = 1'b0;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g.fa = ForwardAE; g.fb = ForwardBE; g.sf = StallF; g.sd = StallD;
    g.se = StallE; g.sm = StallM; g.fd = FlushD; g.fe = FlushE; g.fw = FlushW;
    g.err = MemTimeoutErr;
    return g;
  endfunction

  task automatic drive(input in_t i);
    Rs1D = i.rs1d; Rs2D = i.rs2d; Rs1E = i.rs1e; Rs2E = i.rs2e;
    RdE = i.rde; RdM = i.rdm; RdW = i.rdw; ResultSrcE = i.rsrc;
    RegWriteM = i.rwm; RegWriteW = i.rww; PCSrcE = i.pcs;
    MemReqM = i.req; MemAckM = i.ack;
  endtask

  task automatic check_front();
    exp_t  e;
    exp_t  g;
    string nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    g  = sample();
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got fa=%b fb=%b stallFDEM=%b%b%b%b flushDEW=%b%b%b err=%b, want fa=%b fb=%b stallFDEM=%b%b%b%b flushDEW=%b%b%b err=%b",
               nm, g.fa, g.fb, g.sf, g.sd, g.se, g.sm, g.fd, g.fe, g.fw, g.err,
               e.fa, e.fb, e.sf, e.sd, e.se, e.sm, e.fd, e.fe, e.fw, e.err);
    end
  endtask

  // Drive one cycle of stimulus just after a rising edge, check at the falling edge.
  task automatic step(input in_t i, input exp_t e, input string nm);
    drive(i);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];
  in_t  idle;
  in_t  miss;
  in_t  fwd_in;

  initial begin
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    miss   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    fwd_in = mk(0, 0, 5, 5, 0, 5, 5, 2'b00, 1, 1, 0, 0, 0);

    // Forwarding priority and x0 handling.
    tbl[0]  = '{in: mk(0, 0, 5, 0, 0, 5, 5, 2'b00, 1, 1, 0, 0, 0), ex: ex_run(2'b10, 2'b00, 0, 0, 0, 0)};
    tbl[1]  = '{in: mk(0, 0, 5, 0, 0, 5, 5, 2'b00, 0, 1, 0, 0, 0), ex: ex_run(2'b01, 2'b00, 0, 0, 0, 0)};
    tbl[2]  = '{in: mk(0, 0, 0, 0, 0, 5, 5, 2'b00, 1, 1, 0, 0, 0), ex: ex_run(2'b00, 2'b00, 0, 0, 0, 0)};
    tbl[3]  = '{in: mk(0, 0, 3, 9, 0, 9, 3, 2'b00, 1, 1, 0, 0, 0), ex: ex_run(2'b01, 2'b10, 0, 0, 0, 0)};
    tbl[4]  = '{in: mk(0, 0, 0, 6, 0, 6, 6, 2'b00, 0, 1, 0, 0, 0), ex: ex_run(2'b00, 2'b01, 0, 0, 0, 0)};
    // Load-use.
    tbl[5]  = '{in: mk(0, 7, 0, 0, 7, 0, 0, 2'b01, 0, 0, 0, 0, 0), ex: ex_run(2'b00, 2'b00, 1, 0, 1, 0)};
    tbl[6]  = '{in: mk(0, 7, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0), ex: ex_run(2'b00, 2'b00, 0, 0, 0, 0)};
    tbl[7]  = '{in: mk(0, 7, 0, 0, 7, 0, 0, 2'b00, 0, 0, 0, 0, 0), ex: ex_run(2'b00, 2'b00, 0, 0, 0, 0)};
    tbl[8]  = '{in: mk(4, 0, 0, 0, 4, 0, 0, 2'b01, 0, 0, 0, 0, 0), ex: ex_run(2'b00, 2'b00, 1, 0, 1, 0)};
    // Taken branch, and branch coinciding with load-use.
    tbl[9]  = '{in: mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0), ex: ex_run(2'b00, 2'b00, 0, 1, 1, 0)};
    tbl[10] = '{in: mk(0, 7, 0, 0, 7, 0, 0, 2'b01, 0, 0, 1, 0, 0), ex: ex_run(2'b00, 2'b00, 1, 1, 1, 0)};
    // Memory hit in RUN: no stall.
    tbl[11] = '{in: mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1), ex: ex_run(2'b00, 2'b00, 0, 0, 0, 0)};

    rst_n = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;
    step(fwd_in, ex_rst(), "reset_fwd_forced_rf");
    step(miss, ex_rst(), "reset_miss_ignored");
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      step(tbl[k].in, tbl[k].ex, $sformatf("vec%0d", k));
    end

    // Three-cycle miss with a branch pulse buried inside it.
    step(miss, ex_mem(0), "miss_c0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0), ex_mem(0), "miss_c1_branch_masked");
    step(miss, ex_mem(0), "miss_c2");
    step(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1), ex_run(2'b00, 2'b00, 0, 0, 0, 0),
         "miss_ack_releases");
    step(idle, ex_run(2'b00, 2'b00, 0, 0, 0, 0), "miss_back_in_run");
    step(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0), ex_run(2'b00, 2'b00, 0, 1, 1, 0),
         "branch_after_release");

    // Timeout: error sets on the edge closing the TO-th wait cycle.
    for (int c = 0; c < 6; c++) begin
      step(miss, ex_mem(c == 5), $sformatf("timeout_c%0d", c));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1), ex_run(2'b00, 2'b00, 0, 0, 0, 1),
         "timeout_ack_err_sticky");
    step(idle, ex_run(2'b00, 2'b00, 0, 0, 0, 1), "timeout_err_holds");

    // Reset asserted mid-miss.
    step(miss, ex_mem(1), "rstmiss_enter");
    step(miss, ex_mem(1), "rstmiss_wait");
    rst_n = 1'b0;
    step(mk(0, 0, 5, 5, 0, 5, 5, 2'b00, 1, 1, 0, 1, 0), ex_rst(), "rstmiss_outputs_forced");
    rst_n = 1'b1;
    step(idle, ex_run(2'b00, 2'b00, 0, 0, 0, 0), "rstmiss_run_err_clear");

`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if ((StallCycles !== '0) || (LoadUseCount !== '0) || (FlushCount !== '0)) begin
      n_fail++;
      $display("FAIL counters_after_reset: got stall=%0d loaduse=%0d flush=%0d, want 0 0 0",
               StallCycles, LoadUseCount, FlushCount);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
